bcd3_incrementor: RTL and testbench

- Registered three-digit BCD incrementor. Adds 1 to a 3-digit packed-BCD value (000..999) and produces the 3-digit BCD result and a decimal carry-out.
- Serves as the +1 stage for decimal counters and display datapaths.
- One clock, single-cycle latency, simple valid qualifier.

---
 rtl/bcd_pkg.sv | 6 +
 rtl/bcd_digit_inc.sv | 24 ++
 rtl/bcd3_incrementor.sv | 71 +++++++
 tb/tb_bcd3_incrementor.sv | 86 ++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type and sizing constants
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam int BCD_DIGITS = 3;
endpackage

// File: rtl/bcd_digit_inc.sv
// bcd_digit_inc: one combinational BCD +carry stage; bad port exists only with BCD_INVALID_DETECT_EN
module bcd_digit_inc
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       cin,
  output bcd_digit_t digit_out,
  output logic       cout
`ifdef BCD_INVALID_DETECT_EN
  ,
  output logic       bad
`endif
);
  logic top;
  // digits 10..15 saturate like 9 so a stray code still wraps and ripples
  always_comb begin
    top       = digit >= BCD_MAX;
    digit_out = !cin ? digit : top ? 4'd0 : digit + 4'd1;
    cout      = cin & top;
  end
`ifdef BCD_INVALID_DETECT_EN
  assign bad = digit > BCD_MAX;
`endif
endmodule

// File: rtl/bcd3_incrementor.sv
// bcd3_incrementor: registered 3-digit BCD +1 with carry; optional non-BCD error via BCD_INVALID_DETECT_EN
module bcd3_incrementor
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  bcd_digit_t digit0,
  input  bcd_digit_t digit1,
  input  bcd_digit_t digit2,
  output logic       out_valid,
  output bcd_digit_t out0,
  output bcd_digit_t out1,
  output bcd_digit_t out2,
  output logic       carry,
  output logic       err
);
  bcd_digit_t d [BCD_DIGITS];
  bcd_digit_t q [BCD_DIGITS];
  logic [BCD_DIGITS:0] c;
  logic det;
  assign d[0] = digit0;
  assign d[1] = digit1;
  assign d[2] = digit2;
  assign c[0] = 1'b1;
`ifdef BCD_INVALID_DETECT_EN
  logic [BCD_DIGITS-1:0] bad;
  assign det = |bad;
`else
  assign det = 1'b0;
`endif
  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_stage
    bcd_digit_inc u_inc (
      .digit    (d[i]),
      .cin      (c[i]),
      .digit_out(q[i]),
      .cout     (c[i+1])
`ifdef BCD_INVALID_DETECT_EN
      ,
      .bad      (bad[i])
`endif
    );
  end
  // result registers load only on accepted operands; a bad operand forces a zeroed result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
      carry     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out0  <= det ? 4'd0 : q[0];
        out1  <= det ? 4'd0 : q[1];
        out2  <= det ? 4'd0 : q[2];
        carry <= !det & c[BCD_DIGITS];
      end
    end
  end
`ifdef BCD_INVALID_DETECT_EN
  // error flag follows the legality of the most recent accepted operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (in_valid) err <= det;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bcd3_incrementor.sv
// tb_bcd3_incrementor: directed self-checking bench for bcd3_incrementor
module tb_bcd3_incrementor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [3:0] digit0 = '0, digit1 = '0, digit2 = '0;
  logic out_valid, carry, err;
  logic [3:0] out0, out1, out2;
  int passed = 0;
  int total = 0;

  bcd3_incrementor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .digit0(digit0), .digit1(digit1), .digit2(digit2),
    .out_valid(out_valid), .out0(out0), .out1(out1), .out2(out2),
    .carry(carry), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] pk(input bit v, input bit c, input bit e, input int n);
    logic [3:0] h, t, u;
    h = 4'((n / 100) % 10);
    t = 4'((n / 10) % 10);
    u = 4'(n % 10);
    return {v, c, e, h, t, u};
  endfunction

  task automatic chk(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    obs = {out_valid, carry, err, out2, out1, out0};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed v/c/e/digits=%b/%b/%b/%h expected %b/%b/%b/%h",
                tag, obs[14], obs[13], obs[12], obs[11:0], exp[14], exp[13], exp[12], exp[11:0]);
  endtask

  task automatic step(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u, input logic v);
    @(negedge clk);
    digit2 = h; digit1 = t; digit0 = u; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk("reset_state", pk(0, 0, 0, 0));
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 9, 1); chk("009", pk(1, 0, 0, 10));
    step(0, 9, 9, 1); chk("099", pk(1, 0, 0, 100));
    step(1, 9, 9, 1); chk("199", pk(1, 0, 0, 200));
    step(9, 9, 9, 1); chk("999", pk(1, 1, 0, 0));
    step(4, 5, 6, 1); chk("456", pk(1, 0, 0, 457));
    step(1, 2, 3, 0); chk("valid_gate", pk(0, 0, 0, 457));
    step(1, 2, 3, 0); chk("valid_gate_hold", pk(0, 0, 0, 457));
    step(0, 0, 12, 1);
`ifdef BCD_INVALID_DETECT_EN
    chk("non_bcd", pk(1, 0, 1, 0));
`else
    chk("non_bcd", pk(1, 0, 0, 10));
`endif
    step(0, 0, 5, 1); chk("err_clear", pk(1, 0, 0, 6));
    step(9, 9, 8, 1); chk("b2b_998", pk(1, 0, 0, 999));
    step(9, 9, 9, 1); chk("b2b_999", pk(1, 1, 0, 0));
    step(0, 0, 0, 1); chk("b2b_000", pk(1, 0, 0, 1));
    step(2, 4, 7, 1); chk("pre_reset", pk(1, 0, 0, 248));
    @(negedge clk);
    digit2 = 4'd9; digit1 = 4'd9; digit0 = 4'd9; in_valid = 1'b1;
    rst_n = 1'b0;
    #1 chk("async_reset", pk(0, 0, 0, 0));
    @(posedge clk);
    #1 chk("reset_hold", pk(0, 0, 0, 0));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_reset_idle", pk(0, 0, 0, 0));
    step(3, 1, 4, 1); chk("post_reset_first", pk(1, 0, 0, 315));
    for (int n = 0; n < 1000; n++) begin
      step(4'(n / 100), 4'((n / 10) % 10), 4'(n % 10), 1);
      chk($sformatf("sweep_%0d", n), pk(1, n == 999, 0, (n + 1) % 1000));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
